// File: rtl/pla_or_programmer.sv
// Write-side sequencer for the PLA OR plane: one select mask per OR cell, each strobed by a registered one-hot wen.
// Optional PLA_OR_READBACK_EN adds per-cell shadow registers readable through rd_idx/rd_data.
module pla_or_programmer #(
   parameter int NUM_INPUTS  = 5,
   parameter int NUM_OUTPUTS = 4,
   parameter int IDX_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [NUM_INPUTS-1:0]  cfg_data,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   output logic [NUM_INPUTS-1:0]  sel,
   output logic [NUM_OUTPUTS-1:0] wen,
   output logic [IDX_W-1:0]       cur_idx,
   output logic                   busy,
   output logic                   done,
   output logic                   aborted
`ifdef PLA_OR_READBACK_EN
   ,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [NUM_INPUTS-1:0]  rd_data
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_FINISH
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUTS - 1);

   state_t                   state, state_nxt;
   logic [IDX_W-1:0]         idx_nxt;
   logic [NUM_INPUTS-1:0]    sel_nxt;
   logic [NUM_OUTPUTS-1:0]   wen_nxt;
   logic                     cfg_ready_nxt, busy_nxt, done_nxt, aborted_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cur_idx   <= '0;
         sel       <= '0;
         wen       <= '0;
         cfg_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cur_idx   <= idx_nxt;
         sel       <= sel_nxt;
         wen       <= wen_nxt;
         cfg_ready <= cfg_ready_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         aborted   <= aborted_nxt;
      end
   end

   // All outputs are derived from the next state so they are registered and glitch-free.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = cur_idx;
      sel_nxt     = sel;
      aborted_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               state_nxt = S_LOAD;
               idx_nxt   = '0;
            end
         end
         S_LOAD: begin
            if (cfg_valid && cfg_ready) begin
               sel_nxt   = cfg_data;
               state_nxt = S_SETUP;
            end
         end
         S_SETUP:  state_nxt = S_STROBE;
         S_STROBE: state_nxt = S_HOLD;
         S_HOLD: begin
            if (cur_idx == LAST_IDX) begin
               state_nxt = S_FINISH;
            end else begin
               idx_nxt   = cur_idx + IDX_W'(1);
               state_nxt = S_LOAD;
            end
         end
         S_FINISH: begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
         end
         default: state_nxt = S_IDLE;
      endcase

      // Abort overrides everything outside IDLE; sel keeps its last value.
      if (state != S_IDLE && abort) begin
         state_nxt   = S_IDLE;
         idx_nxt     = '0;
         sel_nxt     = sel;
         aborted_nxt = 1'b1;
      end

      cfg_ready_nxt = (state_nxt == S_LOAD);
      busy_nxt      = (state_nxt != S_IDLE);
      done_nxt      = (state_nxt == S_FINISH);
      wen_nxt       = '0;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
         wen_nxt[k] = (state_nxt == S_STROBE) && (idx_nxt == IDX_W'(k));
      end
   end

`ifdef PLA_OR_READBACK_EN
   logic [NUM_INPUTS-1:0] shadow [NUM_OUTPUTS];

   // Mirrors what each cell captured: sel is stable for the whole wen cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_OUTPUTS; k++) shadow[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (wen[k]) shadow[k] <= sel;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
         if (rd_idx == IDX_W'(k)) rd_data = shadow[k];
      end
   end
`endif

endmodule

// File: tb/tb_pla_or_programmer.sv
// Directed bench for pla_or_programmer: reset, full pass, backpressure, abort, ignored start, mid-pass reset.
module tb_pla_or_programmer;
   localparam int NI = 5;
   localparam int NO = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst, start, abort, cfg_valid;
   logic [NI-1:0] cfg_data;
   logic          cfg_ready, busy, done, aborted;
   logic [NI-1:0] sel;
   logic [NO-1:0] wen;
   logic [IW-1:0] cur_idx;
`ifdef PLA_OR_READBACK_EN
   logic [IW-1:0] rd_idx;
   logic [NI-1:0] rd_data;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [NI-1:0] masks [4] = '{5'h03, 5'h1F, 5'h00, 5'h15};
   logic [NO-1:0] exp_wen;

   pla_or_programmer #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .sel(sel), .wen(wen), .cur_idx(cur_idx),
      .busy(busy), .done(done), .aborted(aborted)
`ifdef PLA_OR_READBACK_EN
      , .rd_idx(rd_idx), .rd_data(rd_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
`ifdef PLA_OR_READBACK_EN
      rd_idx = '0;
`endif
      tick; tick;
      chk("rst_sel", sel, 0);
      chk("rst_wen", wen, 0);
      chk("rst_idx", cur_idx, 0);
      chk("rst_ready", cfg_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      rst = 1'b0;
      tick;
      chk("idle_busy", busy, 0);

      // Full pass with cfg_valid always high
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("pass_ready", cfg_ready, 1);
      chk("pass_busy", busy, 1);
      chk("pass_idx0", cur_idx, 0);
      cfg_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cfg_data = masks[k];
         tick;
         chk("setup_sel", sel, masks[k]);
         chk("setup_wen", wen, 0);
         chk("setup_ready", cfg_ready, 0);
         tick;
         exp_wen = 4'b0001 << k;
         chk("strobe_wen", wen, exp_wen);
         chk("strobe_sel", sel, masks[k]);
         chk("strobe_idx", cur_idx, k);
         tick;
         chk("hold_wen", wen, 0);
         chk("hold_sel", sel, masks[k]);
         tick;
         if (k < 3) begin
            chk("load_ready", cfg_ready, 1);
            chk("load_done", done, 0);
            chk("load_wen", wen, 0);
         end else begin
            chk("finish_done", done, 1);
            chk("finish_wen", wen, 0);
         end
      end
      cfg_valid = 1'b0;
      tick;
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_idx", cur_idx, 0);
      chk("post_ready", cfg_ready, 0);
`ifdef PLA_OR_READBACK_EN
      for (int r = 0; r < 4; r++) begin
         rd_idx = IW'(r);
         #1;
         chk("rdback", rd_data, masks[r]);
      end
`endif

      // Backpressure in LOAD idx 2, with an ignored start in the middle
      start = 1'b1;
      tick;
      start = 1'b0;
      cfg_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cfg_data = NI'(k + 1);
         tick; tick; tick; tick;
      end
      cfg_valid = 1'b0;
      cfg_data = 5'h1B;
      for (int i = 0; i < 6; i++) begin
         start = (i == 2);
         tick;
         chk("bp_ready", cfg_ready, 1);
         chk("bp_wen", wen, 0);
         chk("bp_idx", cur_idx, 2);
         chk("bp_busy", busy, 1);
         chk("bp_sel", sel, 5'h02);
      end
      start = 1'b0;
      cfg_valid = 1'b1;
      cfg_data = 5'h0A;
      tick;
      chk("bp_setup_sel", sel, 5'h0A);
      chk("bp_setup_wen", wen, 0);
      tick;
      chk("bp_strobe_wen", wen, 4'b0100);
      chk("bp_strobe_sel", sel, 5'h0A);
      tick; tick;
      cfg_data = 5'h15;
      tick; tick; tick; tick;
      chk("bp_done", done, 1);
      cfg_valid = 1'b0;
      tick;
      chk("bp_post_busy", busy, 0);
      chk("bp_post_done", done, 0);
`ifdef PLA_OR_READBACK_EN
      rd_idx = 2'd2;
      #1;
      chk("bp_rdback", rd_data, 5'h0A);
`endif

      // Abort in SETUP of idx 1
      start = 1'b1;
      tick;
      start = 1'b0;
      cfg_valid = 1'b1;
      cfg_data = 5'h11;
      tick; tick; tick; tick;
      cfg_data = 5'h06;
      tick;
      chk("ab_setup_idx", cur_idx, 1);
      chk("ab_setup_wen", wen, 0);
      abort = 1'b1;
      cfg_valid = 1'b0;
      tick;
      abort = 1'b0;
      chk("ab_aborted", aborted, 1);
      chk("ab_done", done, 0);
      chk("ab_busy", busy, 0);
      chk("ab_wen", wen, 0);
      chk("ab_ready", cfg_ready, 0);
      chk("ab_sel_hold", sel, 5'h06);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("ab_after_wen", wen, 0);
         chk("ab_after_aborted", aborted, 0);
         chk("ab_after_done", done, 0);
      end
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("restart_idx", cur_idx, 0);
      chk("restart_ready", cfg_ready, 1);
      chk("restart_busy", busy, 1);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("ab_load_aborted", aborted, 1);
      tick;
      chk("ab_load_pulse_end", aborted, 0);
      chk("ab_load_busy", busy, 0);

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      tick;
      chk("sa_busy", busy, 0);
      chk("sa_ready", cfg_ready, 0);
      chk("sa_aborted", aborted, 0);
      start = 1'b0;
      abort = 1'b0;
      tick;
      chk("sa2_busy", busy, 0);
      chk("sa2_done", done, 0);
      chk("sa2_aborted", aborted, 0);

      // Asynchronous reset during STROBE of idx 1
      start = 1'b1;
      tick;
      start = 1'b0;
      cfg_valid = 1'b1;
      cfg_data = 5'h07;
      tick; tick; tick; tick;
      cfg_data = 5'h19;
      tick; tick;
      chk("mr_strobe_wen", wen, 4'b0010);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_wen", wen, 0);
      chk("mr_busy", busy, 0);
      chk("mr_sel", sel, 0);
      chk("mr_ready", cfg_ready, 0);
      chk("mr_idx", cur_idx, 0);
`ifdef PLA_OR_READBACK_EN
      for (int r = 0; r < 4; r++) begin
         rd_idx = IW'(r);
         #0.1;
         chk("mr_rdback", rd_data, 0);
      end
`endif
      cfg_valid = 1'b0;
      tick;
      rst = 1'b0;
      tick;
      chk("mr_post_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
